// File: rtl/latch_bank_ctrl.sv
// Writes requester data into a bank of latch groups via a SETUP/OPEN/CLOSE enable sequence.
// Latency: grant edge to ack is 3 cycles, valid visible 4 cycles after grant; one write per 4 cycles.
// Backpressure: requests wait (no ack) while every way is valid; requesters hold req until ack.
module latch_bank_ctrl #(
    parameter int WAY   = 3,
    parameter int WIRE  = 8,
    parameter int NREQ  = 2,
    parameter int WAY_W = (WAY > 1) ? $clog2(WAY) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIRE-1:0]   req_data,
    input  logic [WAY-1:0]         rel,
    output logic [NREQ-1:0]        ack,
    output logic [WAY_W-1:0]       ack_way,
    output logic [WAY-1:0]         lat_clk,
    output logic [WAY*WIRE-1:0]    lat_D,
    output logic [WAY-1:0]         valid,
    output logic                   full
);

    localparam int REQ_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [REQ_W-1:0]   rr_ptr;
    logic [REQ_W-1:0]   gnt_idx;
    logic [REQ_W-1:0]   gnt_pick;
    logic [REQ_W:0]     rr_idx;
    logic               gnt_vld;
    logic [WAY_W-1:0]   sel_way;
    logic [WAY_W-1:0]   free_way;
    logic [WIRE-1:0]    data_q;
    logic [WAY-1:0]     sel_oh;
    logic [WAY-1:0]     busy_mask;
    logic [WAY-1:0]     lat_clk_nxt;

    assign full  = &valid;
    assign lat_D = {WAY{data_q}};

    // Round-robin pick: scan from rr_ptr upward, lowest offset wins.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_pick = '0;
        rr_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            rr_idx = {1'b0, rr_ptr} + (REQ_W+1)'(k);
            if (rr_idx >= (REQ_W+1)'(NREQ)) begin
                rr_idx = rr_idx - (REQ_W+1)'(NREQ);
            end
            if (req[rr_idx[REQ_W-1:0]]) begin
                gnt_vld  = 1'b1;
                gnt_pick = rr_idx[REQ_W-1:0];
            end
        end
    end

    always_comb begin
        free_way = '0;
        for (int k = WAY - 1; k >= 0; k--) begin
            if (!valid[k]) begin
                free_way = WAY_W'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_vld && !full) state_nxt = SETUP;
            SETUP:   state_nxt = OPEN;
            OPEN:    state_nxt = CLOSE;
            CLOSE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // lat_clk is computed one cycle early and registered so the latch enables never glitch.
    always_comb begin
        sel_oh      = WAY'(1) << sel_way;
        lat_clk_nxt = (state_nxt == OPEN) ? sel_oh : '0;
        busy_mask   = (state != IDLE) ? sel_oh : '0;
        ack         = (state == CLOSE) ? (NREQ'(1) << gnt_idx) : '0;
        ack_way     = (state == CLOSE) ? sel_way : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            sel_way <= '0;
            data_q  <= '0;
            lat_clk <= '0;
            valid   <= '0;
        end else begin
            lat_clk <= lat_clk_nxt;
            if (state == IDLE && state_nxt == SETUP) begin
                gnt_idx <= gnt_pick;
                sel_way <= free_way;
                data_q  <= req_data[gnt_pick*WIRE +: WIRE];
                rr_ptr  <= (gnt_pick == REQ_W'(NREQ - 1)) ? '0 : gnt_pick + 1'b1;
            end
            // Releases aimed at the way being written are dropped.
            valid <= (valid & ~(rel & ~busy_mask)) | ((state == CLOSE) ? sel_oh : '0);
        end
    end

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Randomized bench for latch_bank_ctrl against a transaction-level model (age of in-flight write).
module tb_latch_bank_ctrl;

    localparam int WAY   = 3;
    localparam int WIRE  = 8;
    localparam int NREQ  = 2;
    localparam int WAY_W = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*WIRE-1:0] req_data;
    logic [WAY-1:0]       rel;
    logic [NREQ-1:0]      ack;
    logic [WAY_W-1:0]     ack_way;
    logic [WAY-1:0]       lat_clk;
    logic [WAY*WIRE-1:0]  lat_D;
    logic [WAY-1:0]       valid;
    logic                 full;

    int n_chk;
    int n_fail;

    // Model: m_age = cycles since the in-flight write was granted (0 = none in flight).
    logic [WAY-1:0]  m_valid;
    int              m_rr;
    int              m_age;
    int              m_way;
    int              m_gnt;
    logic [WIRE-1:0] m_data;

    latch_bank_ctrl #(
        .WAY   (WAY),
        .WIRE  (WIRE),
        .NREQ  (NREQ),
        .WAY_W (WAY_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .rel      (rel),
        .ack      (ack),
        .ack_way  (ack_way),
        .lat_clk  (lat_clk),
        .lat_D    (lat_D),
        .valid    (valid),
        .full     (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_rr    = 0;
        m_age   = 0;
        m_way   = 0;
        m_gnt   = 0;
        m_data  = '0;
    endtask

    task automatic model_edge();
        logic [WAY-1:0] nv;
        bit             found;
        if (!rst_n) begin
            model_reset();
        end else begin
            nv = m_valid;
            for (int k = 0; k < WAY; k++) begin
                if (rel[k] && !(m_age != 0 && k == m_way)) nv[k] = 1'b0;
            end
            if (m_age == 3) begin
                nv[m_way] = 1'b1;
                m_age     = 0;
            end else if (m_age != 0) begin
                m_age++;
            end else if (req != '0 && m_valid != '1) begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && req[(m_rr + k) % NREQ]) begin
                        m_gnt = (m_rr + k) % NREQ;
                        found = 1'b1;
                    end
                end
                for (int k = WAY - 1; k >= 0; k--) begin
                    if (!m_valid[k]) m_way = k;
                end
                m_data = req_data[m_gnt*WIRE +: WIRE];
                m_rr   = (m_gnt + 1) % NREQ;
                m_age  = 1;
            end
            m_valid = nv;
        end
    endtask

    task automatic check_outputs();
        logic [WAY-1:0]  e_lc;
        logic [NREQ-1:0] e_ack;
        e_lc  = (m_age == 2) ? (WAY'(1) << m_way) : '0;
        e_ack = (m_age == 3) ? (NREQ'(1) << m_gnt) : '0;
        chk_eq("lat_clk", lat_clk, e_lc);
        chk_eq("ack", ack, e_ack);
        if (m_age == 3) chk_eq("ack_way", ack_way, m_way);
        chk_eq("lat_D", lat_D, {WAY{m_data}});
        chk_eq("valid", valid, m_valid);
        chk_eq("full", full, &m_valid);
        chk_eq("lat_clk_onehot", $countones(lat_clk) <= 1, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rand_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && m_age == 3 && m_gnt == i) begin
                req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                req[i] = 1'b1;
                req_data[i*WIRE +: WIRE] = WIRE'($urandom);
            end
        end
        rel = ($urandom_range(0, 9) == 0) ? WAY'($urandom) : '0;
    endtask

    initial begin
        int guard;
        n_chk    = 0;
        n_fail   = 0;
        req      = '0;
        req_data = '0;
        rel      = '0;
        rst_n    = 1'b1;
        model_reset();

        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_ack", ack, 2'b00);
        chk_eq("rst_ack_way", ack_way, 2'd0);
        chk_eq("rst_lat_clk", lat_clk, 3'b000);
        chk_eq("rst_lat_D", lat_D, 24'h0);
        chk_eq("rst_valid", valid, 3'b000);
        chk_eq("rst_full", full, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write from requester 0.
        req_data = 16'h33A5;
        req      = 2'b01;
        step();
        chk_eq("w0_setup_lat_D", lat_D, 24'hA5A5A5);
        chk_eq("w0_setup_lat_clk", lat_clk, 3'b000);
        step();
        chk_eq("w0_open_lat_clk", lat_clk, 3'b001);
        chk_eq("w0_open_lat_D", lat_D, 24'hA5A5A5);
        step();
        chk_eq("w0_close_ack", ack, 2'b01);
        chk_eq("w0_close_ack_way", ack_way, 2'd0);
        chk_eq("w0_close_lat_clk", lat_clk, 3'b000);
        req = 2'b00;
        step();
        chk_eq("w0_valid", valid, 3'b001);

        // Free way 0, then try to release it while it is being rewritten.
        rel = 3'b001;
        step();
        rel = 3'b000;
        chk_eq("rel_free_valid", valid, 3'b000);
        req_data[7:0] = 8'h3C;
        req = 2'b01;
        step();
        step();
        rel = 3'b001;
        step();
        rel = 3'b000;
        chk_eq("rel_busy_ack", ack, 2'b01);
        req = 2'b00;
        step();
        chk_eq("rel_busy_valid", valid, 3'b001);

        for (int n = 0; n < 400; n++) begin
            rand_stim();
            step();
        end

        // Reset asserted while a write is in OPEN.
        guard = 0;
        while (m_age != 2 && guard < 200) begin
            rand_stim();
            step();
            guard++;
        end
        chk_eq("reach_open", lat_clk != '0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_lat_clk", lat_clk, 3'b000);
        chk_eq("mid_rst_ack", ack, 2'b00);
        chk_eq("mid_rst_valid", valid, 3'b000);
        chk_eq("mid_rst_lat_D", lat_D, 24'h0);
        chk_eq("mid_rst_full", full, 1'b0);
        model_reset();
        req = '0;
        rel = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        req_data[7:0] = 8'h5A;
        req = 2'b01;
        step();
        chk_eq("restart_setup_lat_D", lat_D, 24'h5A5A5A);
        step();
        chk_eq("restart_open_lat_clk", lat_clk, 3'b001);
        step();
        chk_eq("restart_ack", ack, 2'b01);
        chk_eq("restart_ack_way", ack_way, 2'd0);
        req = 2'b00;
        step();
        chk_eq("restart_valid", valid, 3'b001);

        for (int n = 0; n < 300; n++) begin
            rand_stim();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/latch_bank_ctrl.md
LATCH_BANK_CTRL -- requirements
Module: latch_bank_ctrl

Interface
REQ-001 Parameters SHALL be: WAY, default 3, latch groups in bank; WIRE, default 8, bits per group; NREQ, default 2, requesters; WAY_W = max(1, clog2(WAY)), slot-index width.
REQ-002 clk  in  1  sole clock, rising-edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req  in  NREQ  per-requester write request, level.
REQ-005 req_data  in  NREQ*WIRE  write data; requester i owns slice [i*WIRE +: WIRE].
REQ-006 rel  in  WAY  per-way release strobe.
REQ-007 ack  out  NREQ  one-cycle pulse to the requester whose write completed.
REQ-008 ack_way  out  WAY_W  way index written; valid only while ack is non-zero.
REQ-009 lat_clk  out  WAY  per-way enable to latch bank clk inputs; at most one bit high.
REQ-010 lat_D  out  WAY*WIRE  captured data, replicated to every way slice.
REQ-011 valid  out  WAY  way holds live data.
REQ-012 full  out  1  equals &valid.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, OPEN, CLOSE; one state per cycle outside IDLE.
REQ-014 In IDLE, with |req and !full at a rising edge: grant one requester round-robin; capture its data into an internal WIRE register; select the lowest-index way with valid=0; go to SETUP.
REQ-015 SETUP: lat_D driven from the captured register; lat_clk all 0; go to OPEN.
REQ-016 OPEN: lat_clk[sel_way]=1 for exactly one cycle; lat_D unchanged; go to CLOSE.
REQ-017 CLOSE: lat_clk all 0; lat_D still held (hold time); ack[granted]=1; ack_way=sel_way; valid[sel_way] set at the edge leaving CLOSE; go to IDLE.
REQ-018 Latency: request sampled at edge t gives ack high in cycle t+3 and valid visible at t+4; back-to-back throughput is one write per 4 cycles.
REQ-019 Round-robin: after granting requester i, priority order starts at (i+1) mod NREQ; reset priority starts at requester 0.
REQ-020 Requesters SHALL hold req until ack; data is sampled only at grant; deasserting req after grant does not abort the write.
REQ-021 Full: no grant while full=1; req stays pending with no ack.
REQ-022 rel[k] clears valid[k] at the next edge; rel on an already-invalid way has no effect.
REQ-023 rel on the way currently in SETUP/OPEN/CLOSE SHALL be ignored.
REQ-024 A release and a grant at the same edge: the grant uses valid as it was before that edge; the freed way is usable from the next IDLE decision.
REQ-025 lat_clk SHALL be registered, with no glitches; lat_D SHALL never change in a cycle where any lat_clk bit is high or in the cycle before or after it.

Reset
REQ-026 While rst_n=0: state=IDLE, lat_clk=0, ack=0, ack_way=0, valid=0, full=0, lat_D=0, round-robin pointer=0; takes effect immediately, without a clock edge.
REQ-027 Reset asserted mid-write SHALL abort the write with no ack; bank contents are undefined and valid=0 marks every way free.
REQ-028 Release from reset is synchronous to clk; the first grant can occur at the first edge with rst_n=1.

Verification (WAY=3, WIRE=8, NREQ=2)
REQ-029 req=01, data0=0xA5 at edge 0 -> lat_clk=001 in cycle 2 only; lat_D=0xA5 in cycles 1-3; ack=01, ack_way=0 in cycle 3; valid=001 in cycle 4.
REQ-030 req=11 held with data0=0x11, data1=0x22 -> grants alternate 0,1,0; ways 0,1,2 are filled with 0x11, 0x22, 0x11; full=1; the next request gets no ack.
REQ-031 Bank full, req=10 pending, rel=010 for one cycle -> valid=101, then a grant into way 1 with ack=10, ack_way=1.
REQ-032 rel=001 issued while way 0 is in OPEN -> release ignored; valid[0]=1 after CLOSE.
REQ-033 rst_n low during OPEN -> lat_clk=000 immediately; no ack; valid=000; after release, req=01 restarts from SETUP into way 0.
REQ-034 Invariant check on every cycle: popcount(lat_clk)<=1; lat_D stable from SETUP through CLOSE; full == &valid.
